// File: rtl/ring_osc_scheduler.sv
// Time-shares one frequency-measurement gate across a bank of ring oscillators:
// settle, count divided-output edges over a fixed window, report on valid/ready.
module ring_osc_scheduler #(
    parameter  int N_RINGS       = 4,
    parameter  int GATE_CYCLES   = 12000,
    parameter  int SETTLE_CYCLES = 16,
    parameter  int CNT_W         = 16,
    localparam int SEL_W         = (N_RINGS > 1) ? $clog2(N_RINGS) : 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start_i,
    input  logic               continuous_i,
    input  logic               ring_div_i,
    output logic [N_RINGS-1:0] ring_en_o,
    output logic [SEL_W-1:0]   ring_sel_o,
    output logic               busy_o,
    // Result handshake: a result transfers on any clk edge where result_valid_o
    // and result_ready_i are both high; id/count/ovf stay frozen while valid waits.
    output logic               result_valid_o,
    input  logic               result_ready_i,
    output logic [SEL_W-1:0]   result_id_o,
    output logic [CNT_W-1:0]   result_count_o,
    output logic               result_ovf_o,
    output logic [1:0]         dbg_state_o
);

    localparam int MAX_T = (GATE_CYCLES > SETTLE_CYCLES) ? GATE_CYCLES : SETTLE_CYCLES;
    localparam int TW    = $clog2(MAX_T + 1);
    localparam logic [TW-1:0]    SETTLE_LAST = TW'(SETTLE_CYCLES - 1);
    localparam logic [TW-1:0]    GATE_LAST   = TW'(GATE_CYCLES - 1);
    localparam logic [SEL_W-1:0] SEL_LAST    = SEL_W'(N_RINGS - 1);
    localparam logic [CNT_W-1:0] CNT_MAX     = '1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SETTLE  = 2'd1,
        ST_MEASURE = 2'd2,
        ST_REPORT  = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [SEL_W-1:0]   sel_q, sel_d;
    logic [TW-1:0]      timer_q, timer_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               ovf_q, ovf_d;
    logic               valid_q, valid_d;
    logic [SEL_W-1:0]   rid_q, rid_d;
    logic [CNT_W-1:0]   rcnt_q, rcnt_d;
    logic               rovf_q, rovf_d;
    logic [N_RINGS-1:0] ring_en_q, ring_en_d;
    logic               busy_q, busy_d;
    logic               sync1_q, sync2_q, prev_q;
    logic               rise;

    // ring_div_i is asynchronous; only the second synchronizer stage is edge-detected.
    assign rise = sync2_q & ~prev_q;

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        timer_d = timer_q;
        count_d = count_q;
        ovf_d   = ovf_q;
        valid_d = valid_q;
        rid_d   = rid_q;
        rcnt_d  = rcnt_q;
        rovf_d  = rovf_q;
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    sel_d   = '0;
                    timer_d = '0;
                    state_d = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (timer_q == SETTLE_LAST) begin
                    timer_d = '0;
                    count_d = '0;
                    ovf_d   = 1'b0;
                    state_d = ST_MEASURE;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            ST_MEASURE: begin
                if (rise) begin
                    if (count_q == CNT_MAX) ovf_d = 1'b1;
                    else                    count_d = count_q + 1'b1;
                end
                // Latch from the _d values so a rise on the final cycle is included.
                if (timer_q == GATE_LAST) begin
                    rcnt_d  = count_d;
                    rovf_d  = ovf_d;
                    rid_d   = sel_q;
                    valid_d = 1'b1;
                    timer_d = '0;
                    state_d = ST_REPORT;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            ST_REPORT: begin
                if (valid_q && result_ready_i) begin
                    valid_d = 1'b0;
                    if (sel_q == SEL_LAST && !continuous_i) begin
                        sel_d   = '0;
                        state_d = ST_IDLE;
                    end else begin
                        sel_d   = (sel_q == SEL_LAST) ? '0 : sel_q + 1'b1;
                        state_d = ST_SETTLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
        busy_d    = (state_d != ST_IDLE);
        ring_en_d = (state_d == ST_SETTLE || state_d == ST_MEASURE) ?
                    (N_RINGS'(1) << sel_d) : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            sel_q     <= '0;
            timer_q   <= '0;
            count_q   <= '0;
            ovf_q     <= 1'b0;
            valid_q   <= 1'b0;
            rid_q     <= '0;
            rcnt_q    <= '0;
            rovf_q    <= 1'b0;
            ring_en_q <= '0;
            busy_q    <= 1'b0;
            sync1_q   <= 1'b0;
            sync2_q   <= 1'b0;
            prev_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            timer_q   <= timer_d;
            count_q   <= count_d;
            ovf_q     <= ovf_d;
            valid_q   <= valid_d;
            rid_q     <= rid_d;
            rcnt_q    <= rcnt_d;
            rovf_q    <= rovf_d;
            ring_en_q <= ring_en_d;
            busy_q    <= busy_d;
            sync1_q   <= ring_div_i;
            sync2_q   <= sync1_q;
            prev_q    <= sync2_q;
        end
    end

    assign ring_en_o      = ring_en_q;
    assign ring_sel_o     = sel_q;
    assign busy_o         = busy_q;
    assign result_valid_o = valid_q;
    assign result_id_o    = rid_q;
    assign result_count_o = rcnt_q;
    assign result_ovf_o   = rovf_q;
    assign dbg_state_o    = state_q;

endmodule
